// File: rtl/clock_divider_multi.sv
// clock_divider_multi: multi-channel programmable 50% duty clock divider.
// Each channel toggles its clk_out every half_q input cycles. New half-periods
// arrive over a valid/ready config port. A running channel only picks up a new
// value at a period boundary (clk_out 1->0), so outputs never produce runt pulses.
// Optional feature macro: CLKDIV_TICK_EN adds tick_out, a registered one-cycle
// pulse on every 0->1 transition of the matching clk_out.

module clock_divider_multi #(
    parameter int  NUM_CH       = 4,
    parameter int  CNT_W        = 32,
    parameter int  DEFAULT_HALF = 25_000_000,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
`ifdef CLKDIV_TICK_EN
    output logic [NUM_CH-1:0] tick_out,
`endif
    output logic [NUM_CH-1:0] clk_out
);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_DRAIN
    } ch_state_e;

    localparam logic [CNT_W-1:0] DEFAULT_HALF_L = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE            = CNT_W'(1);

    logic              chInRange;
    logic              halfIsZero;
    logic [NUM_CH-1:0] chSel;
    logic [NUM_CH-1:0] pendVec;
    logic              cfgErr_d;
    logic              cfgErr_q;

    // Decode the config request: target channel, readiness and illegality.
    always_comb begin
        chInRange  = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
        halfIsZero = (cfg_half == '0);
        chSel      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chSel[i] = chInRange && (cfg_ch == CH_W'(i));
        end
        cfg_ready = ~|(chSel & pendVec);
        cfgErr_d  = cfg_valid && cfg_ready && (!chInRange || halfIsZero);
    end

    // Error flag: one-cycle pulse after an illegal request is discarded.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfgErr_d;
        end
    end

    assign cfg_err = cfgErr_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        ch_state_e        state;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] half_q;
        logic [CNT_W-1:0] half_d;
        logic [CNT_W-1:0] pend_q;
        logic [CNT_W-1:0] pend_d;
        logic             clk_q;
        logic             clk_d;
        logic             pendV_q;
        logic             pendV_d;
        logic             wrap;
        logic             boundary;
        logic             accept;

        // Channel next state: count, toggle, apply pending half at boundary, take config.
        always_comb begin
            state    = CH_IDLE;
            cnt_d    = cnt_q;
            clk_d    = clk_q;
            half_d   = half_q;
            pend_d   = pend_q;
            pendV_d  = pendV_q;
            boundary = 1'b0;
            wrap     = (cnt_q == (half_q - ONE));
            accept   = cfg_valid && cfg_ready && !halfIsZero && chSel[g];

            if (en[g]) begin
                state = CH_RUN;
            end else if (clk_q) begin
                state = CH_DRAIN;
            end

            if (state == CH_IDLE) begin
                cnt_d = '0;
            end else if (wrap) begin
                cnt_d    = '0;
                clk_d    = ~clk_q;
                boundary = clk_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end

            if (boundary && pendV_q) begin
                half_d  = pend_q;
                pendV_d = 1'b0;
            end

            if (accept) begin
                if (state == CH_IDLE) begin
                    half_d = cfg_half;
                end else begin
                    pend_d  = cfg_half;
                    pendV_d = 1'b1;
                end
            end
        end

        // Channel state registers; reset restores the default half-period.
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                cnt_q   <= '0;
                clk_q   <= 1'b0;
                half_q  <= DEFAULT_HALF_L;
                pend_q  <= '0;
                pendV_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                clk_q   <= clk_d;
                half_q  <= half_d;
                pend_q  <= pend_d;
                pendV_q <= pendV_d;
            end
        end

        assign pendVec[g] = pendV_q;
        assign clk_out[g] = clk_q;

`ifdef CLKDIV_TICK_EN
        logic tick_q;

        // Tick pulse registered on the same edge that raises clk_out.
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= (state != CH_IDLE) && wrap && !clk_q;
            end
        end

        assign tick_out[g] = tick_q;
`endif
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Testbench for clock_divider_multi: table-driven cycle vectors plus
// hand-written sequences for drain, boundary-edge config, half=1,
// async reset and out-of-range channel requests.

module tb_clock_divider_multi;

    typedef struct {
        logic [3:0] en;
        logic       valid;
        logic [1:0] ch;
        logic [7:0] half;
        logic       rdy;
        logic [3:0] clk;
        logic       err;
    } vec_t;

    logic       clk_in;
    logic       reset;
    logic [3:0] en;
    logic       cfgValid;
    logic       cfgReady;
    logic [1:0] cfgCh;
    logic [7:0] cfgHalf;
    logic       cfgErr;
    logic [3:0] clkOut;
    logic [3:0] tickOut;

    logic [2:0] en2;
    logic       cfgValid2;
    logic       cfgReady2;
    logic [1:0] cfgCh2;
    logic [7:0] cfgHalf2;
    logic       cfgErr2;
    logic [2:0] clkOut2;
    logic [2:0] tickOut2;

    int   total;
    int   bad;
    vec_t tbl[$];

    clock_divider_multi #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .DEFAULT_HALF(3)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .cfg_valid(cfgValid),
        .cfg_ready(cfgReady),
        .cfg_ch   (cfgCh),
        .cfg_half (cfgHalf),
        .cfg_err  (cfgErr),
`ifdef CLKDIV_TICK_EN
        .tick_out (tickOut),
`endif
        .clk_out  (clkOut)
    );

    clock_divider_multi #(
        .NUM_CH      (3),
        .CNT_W       (8),
        .DEFAULT_HALF(2)
    ) dut2 (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en2),
        .cfg_valid(cfgValid2),
        .cfg_ready(cfgReady2),
        .cfg_ch   (cfgCh2),
        .cfg_half (cfgHalf2),
        .cfg_err  (cfgErr2),
`ifdef CLKDIV_TICK_EN
        .tick_out (tickOut2),
`endif
        .clk_out  (clkOut2)
    );

`ifndef CLKDIV_TICK_EN
    assign tickOut  = 4'b0000;
    assign tickOut2 = 3'b000;
`endif

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] e, input logic v, input logic [1:0] c, input logic [7:0] h);
        en       = e;
        cfgValid = v;
        cfgCh    = c;
        cfgHalf  = h;
    endtask

    task automatic nextCycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(4'b0000, 1'b0, 2'd0, 8'd0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic addRow(input logic [3:0] e, input logic v, input logic [1:0] c, input logic [7:0] h,
                          input logic r, input logic [3:0] k, input logic er);
        tbl.push_back('{e, v, c, h, r, k, er});
    endtask

    initial begin
        logic [3:0] prevClk;
        logic       expD [16];
        logic       expB [15];
        logic       prevBit;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 2'd0, 8'd0);
        en2       = 3'b000;
        cfgValid2 = 1'b0;
        cfgCh2    = 2'd0;
        cfgHalf2  = 8'd0;

        // Main scenario: ch0 at half 3, reconfigure to 5 mid high phase, then 7;
        // ch1 loaded with 2 while idle and enabled later; illegal half=0 on ch2.
        addRow(4'b0001, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 1'b0);
        addRow(4'b0001, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 1'b0);
        addRow(4'b0001, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0001, 1'b0);
        addRow(4'b0001, 1'b1, 2'd0, 8'd5, 1'b1, 4'b0001, 1'b0);
        addRow(4'b0001, 1'b1, 2'd0, 8'd7, 1'b0, 4'b0001, 1'b0);
        addRow(4'b0001, 1'b1, 2'd1, 8'd2, 1'b1, 4'b0000, 1'b0);
        addRow(4'b0001, 1'b1, 2'd0, 8'd7, 1'b1, 4'b0000, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0010, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0010, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0011, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0010, 1'b0);
        addRow(4'b0011, 1'b1, 2'd2, 8'd0, 1'b1, 4'b0010, 1'b1);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0010, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0010, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0011, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0011, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0001, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0011, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0010, 1'b0);
        addRow(4'b0011, 1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 1'b0);

        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("reset clk_out", 32'(clkOut), 32'h0);
        checkOutput("reset cfg_err", 32'(cfgErr), 32'h0);
        checkOutput("reset cfg_ready", 32'(cfgReady), 32'h1);
        checkOutput("reset tick_out", 32'(tickOut), 32'h0);
        checkOutput("reset dut2 clk_out", 32'(clkOut2), 32'h0);
        reset = 1'b0;

        $display("[TB] table vectors: %0d rows", tbl.size());
        prevClk = 4'b0000;
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].en, tbl[i].valid, tbl[i].ch, tbl[i].half);
            #1;
            checkOutput($sformatf("row%0d cfg_ready", i + 1), 32'(cfgReady), 32'(tbl[i].rdy));
            nextCycle();
            checkOutput($sformatf("row%0d clk_out", i + 1), 32'(clkOut), 32'(tbl[i].clk));
            checkOutput($sformatf("row%0d cfg_err", i + 1), 32'(cfgErr), 32'(tbl[i].err));
`ifdef CLKDIV_TICK_EN
            checkOutput($sformatf("row%0d tick_out", i + 1), 32'(tickOut), 32'(tbl[i].clk & ~prevClk));
`endif
            prevClk = tbl[i].clk;
        end

        // Accept exactly on a boundary edge: stored as pending, applied one period later (half=1).
        $display("[TB] sequence: boundary-edge config and half=1");
        resetDut();
        expD = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        prevBit = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            applyStimulus(4'b1000, (e == 6), 2'd3, 8'd1);
            #1;
            checkOutput($sformatf("bnd e%0d cfg_ready", e), 32'(cfgReady), 32'((e >= 7 && e <= 12) ? 1'b0 : 1'b1));
            nextCycle();
            checkOutput($sformatf("bnd e%0d clk_out", e), 32'(clkOut), 32'({expD[e-1], 3'b000}));
`ifdef CLKDIV_TICK_EN
            checkOutput($sformatf("bnd e%0d tick_out", e), 32'(tickOut), 32'({expD[e-1] & ~prevBit, 3'b000}));
`endif
            prevBit = expD[e-1];
        end

        // Drain: idle load of half=4 on ch2, en dropped right after the rise, then re-raised.
        $display("[TB] sequence: drain and re-enable");
        resetDut();
        applyStimulus(4'b0000, 1'b1, 2'd2, 8'd4);
        #1;
        checkOutput("drain idle cfg_ready", 32'(cfgReady), 32'h1);
        nextCycle();
        checkOutput("drain idle clk_out", 32'(clkOut), 32'h0);
        expB = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int e = 1; e <= 15; e++) begin
            applyStimulus((e >= 5 && e <= 11) ? 4'b0000 : 4'b0100, 1'b0, 2'd2, 8'd0);
            nextCycle();
            checkOutput($sformatf("drain e%0d clk_out", e), 32'(clkOut), 32'({1'b0, expB[e-1], 2'b00}));
        end

        // Asynchronous reset in the middle of a high phase.
        $display("[TB] sequence: async reset mid-run");
        resetDut();
        applyStimulus(4'b0001, 1'b0, 2'd0, 8'd0);
        repeat (3) nextCycle();
        checkOutput("pre-reset clk_out", 32'(clkOut), 32'h1);
`ifdef CLKDIV_TICK_EN
        checkOutput("pre-reset tick_out", 32'(tickOut), 32'h1);
`endif
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset clk_out", 32'(clkOut), 32'h0);
        checkOutput("async reset tick_out", 32'(tickOut), 32'h0);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;

        // Out-of-range channel on a 3-channel instance: ready, error pulse, no half change.
        $display("[TB] sequence: out-of-range channel");
        en2       = 3'b001;
        cfgValid2 = 1'b1;
        cfgCh2    = 2'd3;
        cfgHalf2  = 8'd5;
        #1;
        checkOutput("oor cfg_ready", 32'(cfgReady2), 32'h1);
        nextCycle();
        cfgValid2 = 1'b0;
        checkOutput("oor cfg_err pulse", 32'(cfgErr2), 32'h1);
        checkOutput("oor e1 clk_out", 32'(clkOut2), 32'h0);
        nextCycle();
        checkOutput("oor cfg_err clear", 32'(cfgErr2), 32'h0);
        checkOutput("oor e2 clk_out", 32'(clkOut2), 32'h1);
        nextCycle();
        checkOutput("oor e3 clk_out", 32'(clkOut2), 32'h1);
        nextCycle();
        checkOutput("oor e4 clk_out", 32'(clkOut2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
